// File: rtl/bdu_bit_feeder_pkg.sv
// ---------------------------------------------------------------------------
// bdu_bit_feeder_pkg
// Shared types and constants for the BDU bit feeder:
//   - array geometry (lanes, coordinate width, dimensions)
//   - BDU_Input: the per-lane bit-serial beat presented to the BDU array
//   - point_t / batch_t: one query point and one {query, refs} batch
//   - feed_state_e: feeder FSM states
//   - coord_bit(): selects one bit of one coordinate of a point
// ---------------------------------------------------------------------------
package bdu_bit_feeder_pkg;

    localparam int NUM_BDU = 8;           // lanes, one reference point each
    localparam int B       = 16;          // coordinate width
    localparam int DIMS    = 3;           // coordinates per point
    localparam int BW      = $clog2(B);   // bit-index width
    localparam int PW      = DIMS * B;    // packed point width
    localparam int RW      = NUM_BDU * PW;
    localparam int ID_W    = 16;

    localparam logic [1:0]    DIM_X    = 2'd0;
    localparam logic [1:0]    DIM_Y    = 2'd1;
    localparam logic [1:0]    DIM_Z    = 2'd2;
    localparam logic [1:0]    DIM_LAST = DIM_Z;
    localparam logic [BW-1:0] BIT_TOP  = BW'(B - 1);

    // Point layout is {z, y, x}: x occupies the low B bits.
    typedef logic [PW-1:0] point_t;
    typedef logic [RW-1:0] ref_batch_t;

    typedef struct packed {
        point_t     query;
        ref_batch_t refs;   // lane i at [i*PW +: PW]
    } batch_t;

    typedef struct packed {
        logic          valid;
        logic          q_bit;
        logic          r_bit;
        logic [1:0]    code;
        logic [BW-1:0] b;
    } BDU_Input;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } feed_state_e;

    function automatic logic coord_bit(input point_t p, input logic [1:0] code,
                                       input logic [BW-1:0] b);
        logic [B-1:0] c;
        case (code)
            DIM_Y:   c = p[B +: B];
            DIM_Z:   c = p[2*B +: B];
            default: c = p[0 +: B];
        endcase
        return c[b];
    endfunction

    // Builds one lane's beat; everything is zero outside streaming so the
    // array sees clean idle values.
    function automatic BDU_Input make_lane(input logic streaming, input logic masked,
                                           input point_t q, input point_t r,
                                           input logic [1:0] code, input logic [BW-1:0] b);
        BDU_Input l;
        l = '0;
        if (streaming) begin
            l.valid = !masked;
            l.q_bit = coord_bit(q, code, b);
            l.r_bit = coord_bit(r, code, b);
            l.code  = code;
            l.b     = b;
        end
        return l;
    endfunction

endpackage

// File: rtl/bdu_bit_feeder_if.sv
// ---------------------------------------------------------------------------
// bdu_bit_feeder_if
// Bundles the feeder's load handshake and its array-facing signals.
//   master : upstream loader / BDU array side (drives loads, term_mask, shift)
//   slave  : the feeder (drives ld_ready, bdu_inputs, batch_id, batch_start)
// Signals:
//   ld_valid/ld_ready  load handshake, fires on ld_valid && ld_ready
//   ld_query, ld_refs  query point {z,y,x} and per-lane reference points
//   term_mask, shift   per-lane terminate and batch retire from the array
//   bdu_inputs         per-lane beat; batch_id / batch_start batch tracking
// ---------------------------------------------------------------------------
interface bdu_bit_feeder_if;
    import bdu_bit_feeder_pkg::*;

    logic                       ld_valid;
    logic                       ld_ready;
    point_t                     ld_query;
    ref_batch_t                 ld_refs;
    logic [NUM_BDU-1:0]         term_mask;
    logic                       shift;
    BDU_Input [NUM_BDU-1:0]     bdu_inputs;
    logic [ID_W-1:0]            batch_id;
    logic                       batch_start;

    modport master (
        output ld_valid, ld_query, ld_refs, term_mask, shift,
        input  ld_ready, bdu_inputs, batch_id, batch_start
    );

    modport slave (
        input  ld_valid, ld_query, ld_refs, term_mask, shift,
        output ld_ready, bdu_inputs, batch_id, batch_start
    );

endinterface

// File: rtl/bdu_bit_feeder_buf.sv
// ---------------------------------------------------------------------------
// bdu_batch_buf
// ACTIVE/SHADOW batch storage for the feeder.
//   clk, rst_n       clock, asynchronous active-low reset
//   load_en_i        accepted load (caller guarantees shadow is free)
//   load_data_i      {query, refs} of the load
//   retire_i         active batch finished; promote shadow (or a same-cycle
//                    load when the shadow is empty)
//   active_o         current active batch contents
//   active_full_o    active batch present
//   shadow_full_o    shadow holds a pending batch
// A load lands in ACTIVE when ACTIVE is empty, otherwise in SHADOW.
// ---------------------------------------------------------------------------
module bdu_batch_buf
    import bdu_bit_feeder_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load_en_i,
    input  batch_t load_data_i,
    input  logic   retire_i,
    output batch_t active_o,
    output logic   active_full_o,
    output logic   shadow_full_o
);

    batch_t active_q, active_d;
    batch_t shadow_q, shadow_d;
    logic   active_full_q, active_full_d;
    logic   shadow_full_q, shadow_full_d;

    always_comb begin
        active_d      = active_q;
        shadow_d      = shadow_q;
        active_full_d = active_full_q;
        shadow_full_d = shadow_full_q;
        if (retire_i) begin
            if (shadow_full_q) begin
                active_d      = shadow_q;
                active_full_d = 1'b1;
                shadow_full_d = 1'b0;
            end else if (load_en_i) begin
                // Load passes through the (empty) shadow straight into ACTIVE.
                active_d      = load_data_i;
                active_full_d = 1'b1;
            end else begin
                active_full_d = 1'b0;
            end
        end else if (load_en_i) begin
            if (!active_full_q) begin
                active_d      = load_data_i;
                active_full_d = 1'b1;
            end else begin
                shadow_d      = load_data_i;
                shadow_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q      <= '0;
            shadow_q      <= '0;
            active_full_q <= 1'b0;
            shadow_full_q <= 1'b0;
        end else begin
            active_q      <= active_d;
            shadow_q      <= shadow_d;
            active_full_q <= active_full_d;
            shadow_full_q <= shadow_full_d;
        end
    end

    assign active_o      = active_q;
    assign active_full_o = active_full_q;
    assign shadow_full_o = shadow_full_q;

endmodule

// File: rtl/bdu_bit_feeder.sv
// ---------------------------------------------------------------------------
// bdu_bit_feeder
// Streams one query point and NUM_BDU reference points bit-serially to the
// BDU array, MSB first with dimensions interleaved (x,y,z of bit B-1, then
// x,y,z of bit B-2, ...). A second batch can wait in a shadow buffer; the
// array's shift retires the active batch and swaps the shadow in without a
// bubble.
// Ports:
//   clk   clock
//   rst   asynchronous active-low reset
//   fb    bdu_bit_feeder_if.slave: load handshake, term_mask/shift in,
//         bdu_inputs/batch_id/batch_start out
// All outputs are decoded from registered state only, so term_mask and
// shift have no combinational path to bdu_inputs.
// ---------------------------------------------------------------------------
module bdu_bit_feeder
    import bdu_bit_feeder_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    bdu_bit_feeder_if.slave  fb
);

    feed_state_e        state_q, state_d;
    logic [BW-1:0]      bit_q, bit_d;
    logic [1:0]         dim_q, dim_d;
    logic [NUM_BDU-1:0] sticky_q, sticky_d;
    logic [ID_W-1:0]    batch_id_q, batch_id_d;

    batch_t active;
    batch_t load_data;
    logic   active_full;
    logic   shadow_full;
    logic   load_fire;
    logic   retire;
    logic   last_beat;
    logic   streaming;

    assign fb.ld_ready = !shadow_full;
    assign load_fire   = fb.ld_valid && !shadow_full;
    // shift only means something while a batch is active.
    assign retire      = fb.shift && (state_q != ST_IDLE);
    assign load_data   = {fb.ld_query, fb.ld_refs};
    assign last_beat   = (bit_q == '0) && (dim_q == DIM_LAST);

    bdu_batch_buf u_buf (
        .clk           (clk),
        .rst_n         (rst),
        .load_en_i     (load_fire),
        .load_data_i   (load_data),
        .retire_i      (retire),
        .active_o      (active),
        .active_full_o (active_full),
        .shadow_full_o (shadow_full)
    );

    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        dim_d      = dim_q;
        sticky_d   = sticky_q;
        batch_id_d = batch_id_q;
        case (state_q)
            ST_IDLE: begin
                if (load_fire) begin
                    state_d  = ST_STREAM;
                    bit_d    = BIT_TOP;
                    dim_d    = DIM_X;
                    sticky_d = '0;
                end
            end
            ST_STREAM, ST_DRAIN: begin
                if (retire) begin
                    batch_id_d = batch_id_q + 1'b1;
                    // A waiting shadow, or a load arriving with the shift,
                    // becomes the next batch starting at beat 0 next cycle.
                    if (shadow_full || load_fire) begin
                        state_d  = ST_STREAM;
                        bit_d    = BIT_TOP;
                        dim_d    = DIM_X;
                        sticky_d = '0;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end else if (state_q == ST_STREAM) begin
                    sticky_d = sticky_q | fb.term_mask;
                    if (last_beat) begin
                        state_d = ST_DRAIN;
                    end else if (dim_q == DIM_LAST) begin
                        dim_d = DIM_X;
                        bit_d = bit_q - 1'b1;
                    end else begin
                        dim_d = dim_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            bit_q      <= '0;
            dim_q      <= '0;
            sticky_q   <= '0;
            batch_id_q <= '0;
        end else begin
            state_q    <= state_d;
            bit_q      <= bit_d;
            dim_q      <= dim_d;
            sticky_q   <= sticky_d;
            batch_id_q <= batch_id_d;
        end
    end

    assign streaming      = (state_q == ST_STREAM) && active_full;
    assign fb.batch_start = streaming && (bit_q == BIT_TOP) && (dim_q == DIM_X);
    assign fb.batch_id    = batch_id_q;

    for (genvar gi = 0; gi < NUM_BDU; gi++) begin : g_lane
        assign fb.bdu_inputs[gi] = make_lane(streaming, sticky_q[gi], active.query,
                                             active.refs[gi*PW +: PW], dim_q, bit_q);
    end

endmodule

// File: tb/tb_bdu_bit_feeder.sv
module tb_bdu_bit_feeder;
    import bdu_bit_feeder_pkg::*;

    localparam int LW = 5 + BW;   // bits per lane in the packed output

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bdu_bit_feeder_if fb();

    bdu_bit_feeder dut (
        .clk (clk),
        .rst (rst),
        .fb  (fb)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard / reference model ----------------
    typedef struct packed {
        logic [PW-1:0] query;
        logic [RW-1:0] refs;
    } exp_batch_t;

    exp_batch_t          sb_q[$];    // [0] = active batch, [1] = shadow
    exp_batch_t          new_b;
    int                  m_state;    // 0 idle, 1 stream, 2 drain
    int                  m_k;
    logic [NUM_BDU-1:0]  m_mask;
    logic [15:0]         m_id;
    bit                  m_fire;
    logic [NUM_BDU-1:0]  vmask;

    function automatic logic [NUM_BDU*LW-1:0] exp_lanes();
        logic [NUM_BDU*LW-1:0] v;
        exp_batch_t cur;
        logic [PW-1:0] rp;
        logic [B-1:0]  cq, cr, tq, tr;
        int bi, cd;
        v   = '0;
        cur = sb_q[0];
        bi  = B - 1 - m_k / DIMS;
        cd  = m_k % DIMS;
        cq  = B'(cur.query >> (cd * B));
        tq  = cq >> bi;
        for (int i = 0; i < NUM_BDU; i++) begin
            rp = PW'(cur.refs >> (i * PW));
            cr = B'(rp >> (cd * B));
            tr = cr >> bi;
            v[i*LW +: LW] = {~m_mask[i], tq[0], tr[0], 2'(cd), BW'(bi)};
        end
        return v;
    endfunction

    initial begin
        m_state = 0; m_k = 0; m_mask = '0; m_id = '0;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                sb_q.delete();
                m_state = 0; m_k = 0; m_mask = '0; m_id = '0;
            end else begin
                m_fire = fb.ld_valid && (sb_q.size() < 2);
                if (m_fire) begin
                    new_b = {fb.ld_query, fb.ld_refs};
                    sb_q.push_back(new_b);
                end
                if (m_state == 0) begin
                    if (m_fire) begin m_state = 1; m_k = 0; m_mask = '0; end
                end else if (fb.shift) begin
                    m_id = m_id + 16'd1;
                    void'(sb_q.pop_front());
                    if (sb_q.size() > 0) begin m_state = 1; m_k = 0; m_mask = '0; end
                    else m_state = 0;
                end else if (m_state == 1) begin
                    m_mask = m_mask | fb.term_mask;
                    if (m_k == DIMS * B - 1) m_state = 2;
                    else m_k++;
                end
            end
        end
    end

    // Monitor: every cycle, compare DUT outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            check_eq("ld_ready", fb.ld_ready, sb_q.size() < 2);
            check_eq("batch_id", fb.batch_id, m_id);
            check_eq("batch_start", fb.batch_start, (m_state == 1) && (m_k == 0));
            if (m_state == 1) begin
                check_eq("beat", fb.bdu_inputs, exp_lanes());
            end else begin
                for (int i = 0; i < NUM_BDU; i++) vmask[i] = fb.bdu_inputs[i].valid;
                check_eq("valid_off", vmask, '0);
                if (m_state == 0) check_eq("idle_lanes", fb.bdu_inputs, '0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [RW-1:0] rand_refs();
        logic [RW-1:0] r;
        for (int w = 0; w < RW / 32; w++) r = {r[RW-33:0], 32'($urandom)};
        return r;
    endfunction

    function automatic logic [PW-1:0] rand_point();
        return {16'($urandom), 16'($urandom), 16'($urandom)};
    endfunction

    task automatic load_batch(input logic [PW-1:0] q, input logic [RW-1:0] r);
        @(posedge clk); #1;
        fb.ld_valid = 1'b1; fb.ld_query = q; fb.ld_refs = r;
        @(posedge clk); #1;
        fb.ld_valid = 1'b0;
    endtask

    task automatic pulse_shift();
        @(posedge clk); #1 fb.shift = 1'b1;
        @(posedge clk); #1 fb.shift = 1'b0;
    endtask

    logic [RW-1:0] refs;
    logic [PW-1:0] qd;
    int            n_beats;
    logic [BW-1:0] last_b;
    logic [1:0]    last_code;

    initial begin
        fb.ld_valid = 1'b0; fb.ld_query = '0; fb.ld_refs = '0;
        fb.term_mask = '0;  fb.shift = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_eq("rst_ready", fb.ld_ready, 1'b1);
        check_eq("rst_lanes", fb.bdu_inputs, '0);
        check_eq("rst_id", fb.batch_id, '0);
        check_eq("rst_start", fb.batch_start, 1'b0);

        // 1: first beat one cycle after the load edge
        refs = rand_refs();
        refs[PW-1:0] = '0;
        load_batch({16'h0000, 16'h0000, 16'h8000}, refs);
        @(negedge clk);
        check_eq("t1_b", fb.bdu_inputs[0].b, 4'd15);
        check_eq("t1_code", fb.bdu_inputs[0].code, 2'd0);
        check_eq("t1_qbit", fb.bdu_inputs[0].q_bit, 1'b1);
        check_eq("t1_rbit", fb.bdu_inputs[0].r_bit, 1'b0);
        check_eq("t1_start", fb.batch_start, 1'b1);
        $display("t1 first beat b=%0d code=%0d", fb.bdu_inputs[0].b, fb.bdu_inputs[0].code);

        // 2: full stream, drain, retire to idle
        n_beats = 1; last_b = '0; last_code = '0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (fb.bdu_inputs[0].valid) begin
                n_beats++;
                last_b    = fb.bdu_inputs[0].b;
                last_code = fb.bdu_inputs[0].code;
            end
        end
        check_eq("t2_beats", n_beats, 48);
        check_eq("t2_last_b", last_b, 4'd0);
        check_eq("t2_last_code", last_code, 2'd2);
        pulse_shift();
        @(negedge clk);
        check_eq("t2_id", fb.batch_id, 16'd1);
        $display("t2 beats=%0d batch_id=%0d", n_beats, fb.batch_id);
        pulse_shift();   // ignored in idle
        @(negedge clk);
        check_eq("idle_shift_id", fb.batch_id, 16'd1);

        // 3: pre-load during stream, shift at beat 10
        load_batch(rand_point(), rand_refs());
        load_batch(rand_point(), rand_refs());
        @(negedge clk);
        check_eq("t3_ready_low", fb.ld_ready, 1'b0);
        repeat (7) @(posedge clk);
        pulse_shift();
        @(negedge clk);
        check_eq("t3_b", fb.bdu_inputs[0].b, 4'd15);
        check_eq("t3_code", fb.bdu_inputs[0].code, 2'd0);
        check_eq("t3_start", fb.batch_start, 1'b1);
        check_eq("t3_id", fb.batch_id, 16'd2);
        check_eq("t3_ready", fb.ld_ready, 1'b1);
        $display("t3 swap batch_id=%0d ld_ready=%0d", fb.batch_id, fb.ld_ready);

        // 4: sticky terminate on lane 3
        repeat (5) @(posedge clk);
        #1 fb.term_mask = 8'h08;
        @(posedge clk); #1 fb.term_mask = '0;
        @(negedge clk);
        check_eq("t4_lane3_off", fb.bdu_inputs[3].valid, 1'b0);
        check_eq("t4_lane2_on", fb.bdu_inputs[2].valid, 1'b1);
        load_batch(rand_point(), rand_refs());
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_eq("t4_lane3_still_off", fb.bdu_inputs[3].valid, 1'b0);
        pulse_shift();
        @(negedge clk);
        check_eq("t4_lane3_back", fb.bdu_inputs[3].valid, 1'b1);
        check_eq("t4_start", fb.batch_start, 1'b1);
        $display("t4 lane3 valid on new batch=%0d", fb.bdu_inputs[3].valid);

        // 5: load and shift in the same cycle with shadow empty
        qd = rand_point();
        @(posedge clk); #1;
        fb.ld_valid = 1'b1; fb.ld_query = qd; fb.ld_refs = rand_refs(); fb.shift = 1'b1;
        @(posedge clk); #1;
        fb.ld_valid = 1'b0; fb.shift = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NUM_BDU; i++) vmask[i] = fb.bdu_inputs[i].valid;
        check_eq("t5_start", fb.batch_start, 1'b1);
        check_eq("t5_valid", vmask, 8'hFF);
        check_eq("t5_qbit", fb.bdu_inputs[0].q_bit, qd[B-1]);
        check_eq("t5_id", fb.batch_id, 16'd4);
        check_eq("t5_ready", fb.ld_ready, 1'b1);
        $display("t5 no-bubble start=%0d batch_id=%0d", fb.batch_start, fb.batch_id);

        // 6: asynchronous reset mid-stream with the shadow full
        load_batch(rand_point(), rand_refs());
        repeat (18) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_eq("t6_lanes", fb.bdu_inputs, '0);
        check_eq("t6_ready", fb.ld_ready, 1'b1);
        check_eq("t6_id", fb.batch_id, '0);
        check_eq("t6_start", fb.batch_start, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        load_batch(rand_point(), rand_refs());
        @(negedge clk);
        check_eq("t6_new_id", fb.batch_id, '0);
        check_eq("t6_new_start", fb.batch_start, 1'b1);
        check_eq("t6_new_b", fb.bdu_inputs[0].b, 4'd15);
        $display("t6 after reset batch_id=%0d start=%0d", fb.batch_id, fb.batch_start);

        repeat (60) @(posedge clk);
        pulse_shift();
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
